// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake and flush.
// Define IF_ID_SKID_EN to add a skid entry so that in_ready is registered (depth 2).
module if_id_pipe_reg #(
  parameter int unsigned      INS_W    = 32,
  parameter int unsigned      PC_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(32'h8000_0000),
  parameter logic [PC_W-1:0]  FLUSH_PC = PC_W'(32'h0000_0000),
  parameter logic [INS_W-1:0] NOP_INS  = INS_W'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [1:0]       occupancy
);

  // The encoding doubles as the occupancy count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             rdy_en_q;
  logic             accept, rel;

  // Holds in_ready low while in reset and releases it one edge after.
  always_ff @(posedge clk) begin
    if (!reset) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign out_valid = (state_q != S_EMPTY);
  assign out_ins   = ins_q;
  assign out_pc    = pc_q;
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign rel       = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
  logic [INS_W-1:0] skid_ins_q, skid_ins_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;

  assign in_ready = rdy_en_q && (state_q != S_FULL);

  always_comb begin
    state_d    = state_q;
    ins_d      = ins_q;
    pc_d       = pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    if (flush) begin
      state_d = S_EMPTY;
      ins_d   = NOP_INS;
      pc_d    = FLUSH_PC;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d = S_ONE;
          ins_d   = in_ins;
          pc_d    = in_pc;
        end
        S_ONE: begin
          if (accept && rel) begin
            ins_d = in_ins;
            pc_d  = in_pc;
          end else if (accept) begin
            state_d    = S_FULL;
            skid_ins_d = in_ins;
            skid_pc_d  = in_pc;
          end else if (rel) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: if (rel) begin
          state_d = S_ONE;
          ins_d   = skid_ins_q;
          pc_d    = skid_pc_q;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      skid_ins_q <= NOP_INS;
      skid_pc_q  <= RESET_PC;
    end else begin
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end
`else
  // Single entry: a slot frees up in the same cycle decode takes the current one.
  assign in_ready = rdy_en_q && (!out_valid || out_ready);

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = S_EMPTY;
      ins_d   = NOP_INS;
      pc_d    = FLUSH_PC;
    end else if (accept) begin
      state_d = S_ONE;
      ins_d   = in_ins;
      pc_d    = in_pc;
    end else if (rel) begin
      state_d = S_EMPTY;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      ins_q   <= NOP_INS;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg; expectations follow the build (IF_ID_SKID_EN or not).
module tb_if_id_pipe_reg;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ins, in_pc, out_ins, out_pc;
  logic [1:0]  occupancy;
  int          n_chk = 0;
  int          n_pass = 0;

  if_id_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ins   = 32'hA000_0000 | pc;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    put(1'b1, 32'hDEAD);

    // Reset held for two edges with a valid entry presented.
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_pc",    out_pc, 32'h8000_0000);
    chk("rst_ins",   out_ins, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ",   {30'd0, occupancy}, 32'd0);
    chk("rst_rdy2",  {31'd0, in_ready}, 32'd0);
    reset = 1'b1; put(1'b0, 32'h0);
    tick();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Streaming with decode always ready.
    out_ready = 1'b1;
    put(1'b1, 32'h100); tick();
    chk("s0_pc", out_pc, 32'h100); chk("s0_occ", {30'd0, occupancy}, 32'd1);
    chk("s0_valid", {31'd0, out_valid}, 32'd1);
    put(1'b1, 32'h104); tick();
    chk("s1_pc", out_pc, 32'h104); chk("s1_occ", {30'd0, occupancy}, 32'd1);
    put(1'b1, 32'h108); tick();
    chk("s2_pc", out_pc, 32'h108); chk("s2_ins", out_ins, 32'hA000_0108);
    chk("s2_occ", {30'd0, occupancy}, 32'd1);
    put(1'b0, 32'h0); tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_keep_pc", out_pc, 32'h108);
    chk("drain_occ", {30'd0, occupancy}, 32'd0);

    // Downstream stall.
    out_ready = 1'b0;
    put(1'b1, 32'h200); tick();
    chk("st0_pc", out_pc, 32'h200); chk("st0_occ", {30'd0, occupancy}, 32'd1);
    put(1'b1, 32'h204);
`ifdef IF_ID_SKID_EN
    chk("st0_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("st1_occ", {30'd0, occupancy}, 32'd2);
    chk("st1_ready", {31'd0, in_ready}, 32'd0);
    chk("st1_pc", out_pc, 32'h200);
    put(1'b0, 32'h0); out_ready = 1'b1;
    chk("st1_ready_nopath", {31'd0, in_ready}, 32'd0);
    tick();
    chk("st2_pc", out_pc, 32'h204); chk("st2_ins", out_ins, 32'hA000_0204);
    chk("st2_occ", {30'd0, occupancy}, 32'd1);
    chk("st2_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("st0_ready_lo", {31'd0, in_ready}, 32'd0);
    tick();
    chk("st1_occ", {30'd0, occupancy}, 32'd1);
    chk("st1_pc", out_pc, 32'h200);
    out_ready = 1'b1; #1;
    chk("st1_ready_follow", {31'd0, in_ready}, 32'd1);
    tick();
    chk("st2_pc", out_pc, 32'h204); chk("st2_ins", out_ins, 32'hA000_0204);
    chk("st2_occ", {30'd0, occupancy}, 32'd1);
    put(1'b0, 32'h0);
`endif
    tick();
    chk("st3_valid", {31'd0, out_valid}, 32'd0);

    // Fill, then flush with a new entry and a release in the same cycle.
    out_ready = 1'b0;
    put(1'b1, 32'h250); tick();
`ifdef IF_ID_SKID_EN
    put(1'b1, 32'h254); tick();
    chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
`else
    chk("fl_pre_occ", {30'd0, occupancy}, 32'd1);
`endif
    flush = 1'b1; out_ready = 1'b1; put(1'b1, 32'h300); tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_pc",    out_pc, 32'h0);
    chk("fl_ins",   out_ins, 32'h0);
    chk("fl_occ",   {30'd0, occupancy}, 32'd0);
    flush = 1'b0; put(1'b0, 32'h0); tick();
    chk("fl_no300_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_no300_pc", out_pc, 32'h0);

    // Reset beats flush.
    put(1'b1, 32'h280); tick();
    chk("pre_rf_pc", out_pc, 32'h280);
    reset = 1'b0; flush = 1'b1; put(1'b1, 32'h284); tick();
    chk("rf_pc",  out_pc, 32'h8000_0000);
    chk("rf_occ", {30'd0, occupancy}, 32'd0);
    reset = 1'b1; flush = 1'b0; put(1'b0, 32'h0); tick();
    put(1'b1, 32'h400); tick();
    chk("final_pc", out_pc, 32'h400);
    chk("final_valid", {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline stage register with a valid/ready handshake, flush, and an optional two-entry skid buffer. It sits between the fetch stage and the decode stage and carries the instruction word and its PC. Downstream stalls propagate upstream without a combinational path through `in_ready` when the skid buffer is compiled in. Flush and reset load fixed, parameter-defined PC and instruction values.

## Interface
Parameters:
- `INS_W`, 32, instruction word width
- `PC_W`, 32, PC width
- `RESET_PC`, 32'h8000_0000, `out_pc` value after reset
- `FLUSH_PC`, 32'h0000_0000, `out_pc` value after flush
- `NOP_INS`, 32'h0000_0000, `out_ins` value after reset or flush

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge
- `reset` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`
- `flush` input 1: discard all held entries
- `in_valid` input 1: fetch presents a valid entry
- `in_ready` output 1: stage can accept an entry this cycle
- `in_ins` input `INS_W`: fetched instruction
- `in_pc` input `PC_W`: PC of `in_ins`
- `out_valid` output 1: `out_ins`/`out_pc` are valid
- `out_ready` input 1: decode accepts the entry this cycle
- `out_ins` output `INS_W`: instruction to decode
- `out_pc` output `PC_W`: PC to decode
- `occupancy` output 2: number of held entries (0–2)

## Operation
- Accept condition: `in_valid && in_ready`. Release condition: `out_valid && out_ready`.
- Storage: a main register drives the outputs; a skid register holds a second entry.
- States: EMPTY (0 entries), ONE (main only), FULL (main + skid). `occupancy` = 0/1/2; `out_valid` = (state != EMPTY).
- `in_ready` = (state != FULL). It depends on state only and has no path from `out_ready`.
- EMPTY: on accept, main ← in, go to ONE.
- ONE:
  - accept and release: main ← in, stay in ONE.
  - accept without release: skid ← in, go to FULL.
  - release without accept: go to EMPTY.
- FULL: accept is impossible. On release, main ← skid, go to ONE.
- Priority: `reset` low > `flush` > handshake.
- Reset: state EMPTY, `out_pc` = `RESET_PC`, `out_ins` = `NOP_INS`, `out_valid` = 0, `in_ready` = 0 during reset and 1 in the first cycle after it.
- Flush: state EMPTY, `out_pc` = `FLUSH_PC`, `out_ins` = `NOP_INS`, skid contents discarded. Any entry presented in the same cycle is dropped, and so is any release.
- Drain to EMPTY without flush: `out_ins`/`out_pc` keep their last values. Consumers must qualify them with `out_valid`.
- Ordering: entries leave strictly in acceptance order. No entry is duplicated or lost except through flush or reset.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N, with `out_valid` = 1 in cycle N+1.
- Throughput: 1 entry/cycle while `out_ready` stays high.
- A downstream stall becomes visible on `in_ready` one cycle later (skid absorbs the in-flight entry).
- All outputs are driven from registers. There is no combinational input-to-output path when `IF_ID_SKID_EN` is defined.
- Reset asserted mid-operation: all entries are lost at that edge, and the outputs take their reset values.

## Configuration
- `IF_ID_SKID_EN` defined:
  - behaviour as above; depth 2, states EMPTY/ONE/FULL.
- `IF_ID_SKID_EN` undefined:
  - no skid register; depth 1, states EMPTY/ONE only, `occupancy` max 1.
  - `in_ready` = `!out_valid || out_ready`, which is combinational from `out_ready`.
  - In ONE, accept without release is impossible. All other rules, reset and flush values are unchanged.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1 -> `out_pc`=0x8000_0000, `out_ins`=0, `out_valid`=0, `occupancy`=0; one cycle after release, `in_ready`=1.
- Streaming: `out_ready`=1, feed PCs 0x100, 0x104, 0x108 on consecutive cycles -> they appear one cycle later on consecutive cycles, in order, with `occupancy`=1 throughout.
- Stall/skid: send 0x200 and 0x204 back-to-back with `out_ready`=0 -> `occupancy`=2 and `in_ready`=0 in the next cycle. Then raise `out_ready` -> 0x200 then 0x204 are released; `in_ready`=1 again after the first release.
- Flush while FULL plus new input: `flush`=1 with `in_valid`=1 and `in_pc`=0x300 -> next cycle `out_valid`=0, `out_pc`=0, `out_ins`=0, `occupancy`=0; 0x300 never appears.
- Flush vs reset: `reset`=0 and `flush`=1 in the same cycle -> `out_pc`=0x8000_0000 (reset wins).
- Non-skid build (`IF_ID_SKID_EN` undefined): with `out_valid`=1, toggle `out_ready` 0→1 -> `in_ready` follows in the same cycle; `occupancy` never exceeds 1.
